lgn_mnist: RTL and testbench

//  Streaming logic-gate-network (LGN) digit classifier. Takes a 16x16 1-bit image as 32 bytes, one per clock.

---
 rtl/lgn_mnist_pkg.sv | 50 +++++
 rtl/lgn_mnist_argmax10.sv | 31 +++
 rtl/lgn_mnist.sv | 123 ++++++++++++
 tb/tb_lgn_mnist.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/lgn_mnist_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module : lgn_mnist_pkg                                                   |
// | Brief  : Shared constants and gate tables for the LGN digit classifier.  |
// |          A_IDX/B_IDX select the two pixels of each gate; OP is the 4-bit |
// |          truth table indexed by {a,b}. Replace the default tables with   |
// |          trained ones; the sizes must stay N_GATES entries.              |
// | Rev    : 1.0 - initial release                                           |
// +--------------------------------------------------------------------------+
package lgn_mnist_pkg;

  localparam int N_CLASSES           = 10;
  localparam int IMG_BITS            = 256;
  localparam int BYTES_PER_IMAGE     = 32;
  localparam int DEF_GATES_PER_CLASS = 25;
  localparam int N_GATES             = N_CLASSES * DEF_GATES_PER_CLASS;

  typedef logic [N_GATES-1:0][7:0] idx_tbl_t;
  typedef logic [N_GATES-1:0][3:0] op_tbl_t;

  // Truth table bit {a,b}=2'b11 set only -> a AND b.
  localparam logic [3:0] OP_AND = 4'b1000;

  // Default wiring: gate j of class c reads pixel c*25+j on both inputs,
  // so with AND the gate simply mirrors that pixel.
  function automatic idx_tbl_t default_idx_tbl();
    idx_tbl_t t;
    t = '0;
    for (int c = 0; c < N_CLASSES; c++) begin
      for (int j = 0; j < DEF_GATES_PER_CLASS; j++) begin
        t[c*DEF_GATES_PER_CLASS + j] = 8'(c*DEF_GATES_PER_CLASS + j);
      end
    end
    return t;
  endfunction

  function automatic op_tbl_t default_op_tbl();
    op_tbl_t t;
    for (int g = 0; g < N_GATES; g++) begin
      t[g] = OP_AND;
    end
    return t;
  endfunction

  localparam idx_tbl_t A_IDX = default_idx_tbl();
  localparam idx_tbl_t B_IDX = default_idx_tbl();
  localparam op_tbl_t  OP    = default_op_tbl();

endpackage
`default_nettype wire

// File: rtl/lgn_mnist_argmax10.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module : lgn_argmax10                                                    |
// | Brief  : Combinational 10-way maximum. Ties resolve to the lowest index. |
// |          Ports: scores (10 x W) in; idx (4b) and max (W) out.            |
// | Rev    : 1.0 - initial release                                           |
// +--------------------------------------------------------------------------+
module lgn_argmax10
  import lgn_mnist_pkg::*;
#(
  parameter int W = 5
) (
  input  logic [N_CLASSES-1:0][W-1:0] scores,
  output logic [3:0]                  idx,
  output logic [W-1:0]                max
);

  // Strict greater-than keeps the earliest index on equal scores.
  always_comb begin
    idx = 4'd0;
    max = scores[0];
    for (int i = 1; i < N_CLASSES; i++) begin
      if (scores[i] > max) begin
        max = scores[i];
        idx = 4'(i);
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/lgn_mnist.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module : lgn_mnist                                                       |
// | Brief  : Streaming logic-gate-network digit classifier. A 256-bit window |
// |          of image bytes feeds one layer of 2-input gates; gate outputs   |
// |          are popcounted per class (stage 1) and the argmax is registered |
// |          (stage 2).                                                      |
// | Ports  : clk, rst (sync, active-high); ui_in image byte; uio_in[7] WE_   |
// |          (active-low shift enable); ena; uo_out winning score;           |
// |          uio_out {4'b0, class}; uio_oe constant 8'h0F.                   |
// | Config : LGN_WE_HOLD_EN - when defined, ena and WE_ gate the shift;      |
// |          otherwise the window advances every cycle.                      |
// | Rev    : 1.0 - initial release                                           |
// +--------------------------------------------------------------------------+
module lgn_mnist
  import lgn_mnist_pkg::*;
#(
  parameter int GATES_PER_CLASS = DEF_GATES_PER_CLASS,
  parameter int SCORE_W         = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] ui_in,
  input  logic [7:0] uio_in,
  input  logic       ena,
  output logic [7:0] uo_out,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  localparam int c_n_gates = N_CLASSES * GATES_PER_CLASS;
  localparam int c_cnt_w   = $clog2(GATES_PER_CLASS + 1);
  localparam int c_sat_max = (1 << SCORE_W) - 1;

  logic [IMG_BITS-1:0]                  r_sr;
  logic                                 w_shift_en;
  logic [c_n_gates-1:0]                 w_gate;
  logic [N_CLASSES-1:0][c_cnt_w-1:0]    w_pop;
  logic [N_CLASSES-1:0][c_cnt_w-1:0]    r_score;
  logic [3:0]                           w_max_idx;
  logic [c_cnt_w-1:0]                   w_max_score;
  logic [SCORE_W-1:0]                   w_score_sat;
  logic [3:0]                           r_out_idx;
  logic [SCORE_W-1:0]                   r_out_score;
  logic                                 w_unused_in;

`ifdef LGN_WE_HOLD_EN
  assign w_shift_en = ena & ~uio_in[7];
`else
  assign w_shift_en = 1'b1;
`endif

  // uio_in[6:0] never matter; uio_in[7]/ena only in the gated build.
  assign w_unused_in = ^{uio_in, ena};

  // Sliding window: newest byte enters at the top, no framing counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sr <= '0;
    end else if (w_shift_en) begin
      r_sr <= {ui_in, r_sr[IMG_BITS-1:8]};
    end
  end

  generate
    for (genvar g = 0; g < c_n_gates; g++) begin : g_gate
      assign w_gate[g] = OP[g][{r_sr[A_IDX[g]], r_sr[B_IDX[g]]}];
    end
  endgenerate

  always_comb begin
    for (int c = 0; c < N_CLASSES; c++) begin
      w_pop[c] = '0;
      for (int j = 0; j < GATES_PER_CLASS; j++) begin
        w_pop[c] = w_pop[c] + c_cnt_w'(w_gate[c*GATES_PER_CLASS + j]);
      end
    end
  end

  // Stage 1: per-class scores.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_score <= '0;
    end else begin
      r_score <= w_pop;
    end
  end

  lgn_argmax10 #(
    .W (c_cnt_w)
  ) u_argmax (
    .scores (r_score),
    .idx    (w_max_idx),
    .max    (w_max_score)
  );

  // Saturation is only needed when the popcount can exceed the output range.
  generate
    if (c_cnt_w > SCORE_W) begin : g_sat
      assign w_score_sat = (32'(w_max_score) > c_sat_max) ? SCORE_W'(c_sat_max)
                                                          : w_max_score[SCORE_W-1:0];
    end else begin : g_nosat
      assign w_score_sat = SCORE_W'(w_max_score);
    end
  endgenerate

  // Stage 2: registered winner.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_idx   <= 4'd0;
      r_out_score <= '0;
    end else begin
      r_out_idx   <= w_max_idx;
      r_out_score <= w_score_sat;
    end
  end

  assign uo_out  = 8'(r_out_score);
  assign uio_out = {4'b0000, r_out_idx};
  assign uio_oe  = 8'h0F;

endmodule
`default_nettype wire

// File: tb/tb_lgn_mnist.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module : tb_lgn_mnist                                                    |
// | Brief  : Directed self-checking bench for lgn_mnist with default gate    |
// |          tables (gate g of class c mirrors pixel c*25+j).                |
// | Config : LGN_WE_HOLD_EN enables the freeze checks.                       |
// | Rev    : 1.0 - initial release                                           |
// +--------------------------------------------------------------------------+
module tb_lgn_mnist;

  logic       clk;
  logic       rst;
  logic [7:0] ui_in;
  logic [7:0] uio_in;
  logic       ena;
  logic [7:0] uo_out;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;

  int n_assert;
  int n_fail;

  logic [255:0] img_zero, img_c3, img_c0c9, img_tie12, img_ones;

  lgn_mnist u_dut (
    .clk     (clk),
    .rst     (rst),
    .ui_in   (ui_in),
    .uio_in  (uio_in),
    .ena     (ena),
    .uo_out  (uo_out),
    .uio_out (uio_out),
    .uio_oe  (uio_oe)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs change 1 time unit after the rising edge; outputs are read there too.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [255:0] px_range(input int lo, input int hi);
    logic [255:0] v;
    v = '0;
    for (int p = lo; p <= hi; p++) v[p] = 1'b1;
    return v;
  endfunction

  // Feed bytes 0..nbytes-1 of an image, one per clock.
  task automatic send_bytes(input logic [255:0] img, input int nbytes);
    for (int k = 0; k < nbytes; k++) begin
      ui_in = img[8*k +: 8];
      tick();
    end
  endtask

  task automatic check(input string tag, input logic [7:0] exp_score, input logic [3:0] exp_idx);
    n_assert++;
    assert (uo_out === exp_score) else begin
      n_fail++;
      $error("FAIL %s score: observed %0d expected %0d", tag, uo_out, exp_score);
    end
    n_assert++;
    assert (uio_out === {4'b0000, exp_idx}) else begin
      n_fail++;
      $error("FAIL %s index: observed 0x%02h expected 0x%02h", tag, uio_out, {4'b0000, exp_idx});
    end
  endtask

  initial begin
    n_assert  = 0;
    n_fail    = 0;
    img_zero  = '0;
    img_c3    = px_range(75, 99);
    img_c0c9  = px_range(0, 9) | px_range(225, 249);
    img_tie12 = px_range(25, 34) | px_range(50, 59);
    img_ones  = '1;

    rst    = 1'b1;
    ena    = 1'b1;
    uio_in = 8'h00;
    ui_in  = 8'h00;
    tick();
    tick();
    rst = 1'b0;

    check("reset", 8'd0, 4'd0);
    n_assert++;
    assert (uio_oe === 8'h0F) else begin
      n_fail++;
      $error("FAIL uio_oe: observed 0x%02h expected 0x0f", uio_oe);
    end

    // Blank image.
    send_bytes(img_zero, 32);
    tick(); tick();
    check("blank", 8'd0, 4'd0);

    // Class-3 group fully lit.
    send_bytes(img_c3, 32);
    tick(); tick();
    check("class3", 8'd25, 4'd3);

    // Class 0 partial (10) vs class 9 full (25).
    send_bytes(img_c0c9, 32);
    tick(); tick();
    check("class9", 8'd25, 4'd9);

    // Classes 1 and 2 tied at 10: lowest index wins.
    send_bytes(img_tie12, 32);
    tick(); tick();
    check("tie12", 8'd10, 4'd1);

    // Every class at 25: ten-way tie resolves to class 0.
    send_bytes(img_ones, 32);
    tick(); tick();
    check("all_ones", 8'd25, 4'd0);

`ifdef LGN_WE_HOLD_EN
    // Freeze with WE_=1 while ui_in churns.
    send_bytes(img_c3, 32);
    uio_in = 8'h80;
    tick(); tick();
    check("freeze_we_start", 8'd25, 4'd3);
    for (int i = 0; i < 40; i++) begin
      ui_in = 8'($urandom);
      tick();
      check("freeze_we", 8'd25, 4'd3);
    end
    // Freeze with ena=0 while WE_ is asserted.
    uio_in = 8'h00;
    ena    = 1'b0;
    for (int i = 0; i < 10; i++) begin
      ui_in = 8'($urandom);
      tick();
      check("freeze_ena", 8'd25, 4'd3);
    end
    ena = 1'b1;
`endif

    // Back-to-back images: class-3 result shows 2 edges into the next image.
    send_bytes(img_c3, 32);
    for (int k = 0; k < 32; k++) begin
      ui_in = img_c0c9[8*k +: 8];
      tick();
      if (k == 1) check("b2b_first", 8'd25, 4'd3);
    end
    tick(); tick();
    check("b2b_second", 8'd25, 4'd9);

    // Reset mid-image clears window and outputs.
    send_bytes(img_c0c9, 16);
    rst = 1'b1;
    tick();
    rst   = 1'b0;
    ui_in = 8'h00;
    check("mid_reset", 8'd0, 4'd0);

    // Half an image after reset lands pixels 75..99 at 203..227:
    // class 8 gets 22, class 9 gets 3.
    send_bytes(img_c3, 16);
    tick(); tick();
    check("half_after_reset", 8'd22, 4'd8);

    // A full 32 bytes restores a valid image.
    send_bytes(img_c3, 32);
    tick(); tick();
    check("full_after_reset", 8'd25, 4'd3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
